// File: rtl/rename_checkpoint_ctrl.sv
// Branch checkpoint controller for the rename stage.
// Holds a circular queue of checkpoints, each with a snapshot of the free-list
// head. Checkpoints are allocated in program order and retire in order once resolved.
// A mispredict on checkpoint K does three things:
//   - it restores the head snapshot of K,
//   - it squashes K and every younger checkpoint,
//   - it emits a one-cycle registered recovery pulse.
module rename_checkpoint_ctrl #(
    parameter int NUM_CP = 8,
    parameter int CP_LOG = 3,
    parameter int FL_LOG = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              recoverFlag_i,
    input  logic              allocReq_i,
    input  logic [FL_LOG-1:0] allocHead_i,
    output logic              allocGnt_o,
    output logic [CP_LOG-1:0] allocId_o,
    output logic              cpFull_o,
    input  logic              resolveValid_i,
    input  logic [CP_LOG-1:0] resolveId_i,
    input  logic              mispredict_i,
    output logic              flagRecoverEX_o,
    output logic              ctrlVerified_o,
    output logic [FL_LOG-1:0] freeListHeadCp_o,
    output logic [NUM_CP-1:0] squashMask_o,
    output logic [CP_LOG:0]   cpCount_o
);

    // Checkpoint storage and queue pointers
    logic [NUM_CP-1:0] valid_q, valid_d;
    logic [NUM_CP-1:0] resolved_q, resolved_d;
    logic [FL_LOG-1:0] head_q [NUM_CP];
    logic [FL_LOG-1:0] head_d [NUM_CP];
    logic [CP_LOG-1:0] oldest_q, oldest_d;
    logic [CP_LOG-1:0] tail_q, tail_d;
    logic [CP_LOG:0]   count_q, count_d;

    // Registered recovery outputs
    logic              flag_q, flag_d;
    logic [FL_LOG-1:0] fl_head_q, fl_head_d;
    logic [NUM_CP-1:0] mask_q, mask_d;

    // Decoded events for this cycle
    logic              cp_full;
    logic              id_valid;
    logic              mis_event;
    logic              correct_event;
    logic              retire_event;
    logic [CP_LOG-1:0] age_k;
    logic [CP_LOG-1:0] age [NUM_CP];
    logic [NUM_CP-1:0] squash;

    assign cp_full       = (count_q == (CP_LOG+1)'(NUM_CP));
    assign id_valid      = valid_q[resolveId_i];
    assign mis_event     = resolveValid_i & mispredict_i & id_valid;
    assign correct_event = resolveValid_i & ~mispredict_i & id_valid;
    assign age_k         = resolveId_i - oldest_q;

    // The oldest entry retires once it is resolved.
    // A correct resolution of the oldest entry in this same cycle also counts,
    // so that entry frees up on the very next edge.
    // A mispredict on the oldest entry squashes it instead of retiring it.
    assign retire_event  = valid_q[oldest_q]
                         & (resolved_q[oldest_q] | (correct_event & (resolveId_i == oldest_q)))
                         & ~(mis_event & (resolveId_i == oldest_q));

    // Age is the distance from the oldest entry.
    // K and everything at or beyond K's age are K itself or younger.
    generate
        for (genvar gi = 0; gi < NUM_CP; gi++) begin : g_age
            assign age[gi]    = CP_LOG'(gi) - oldest_q;
            assign squash[gi] = valid_q[gi] & (age[gi] >= age_k);
        end
    endgenerate

    assign allocGnt_o = allocReq_i & ~stall_i & ~cp_full & ~recoverFlag_i & ~mis_event;
    assign allocId_o  = tail_q;
    assign cpFull_o   = cp_full;
    assign cpCount_o  = count_q;

    assign flagRecoverEX_o  = flag_q;
    assign ctrlVerified_o   = flag_q;
    assign freeListHeadCp_o = fl_head_q;
    assign squashMask_o     = mask_q;

    // Next-state: flush has priority; otherwise alloc, resolve, retire and mispredict combine
    always_comb begin
        valid_d    = valid_q;
        resolved_d = resolved_q;
        head_d     = head_q;
        oldest_d   = oldest_q;
        tail_d     = tail_q;
        count_d    = count_q;
        flag_d     = 1'b0;
        fl_head_d  = '0;
        mask_d     = '0;

        if (recoverFlag_i) begin
            valid_d    = '0;
            resolved_d = '0;
            oldest_d   = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (allocGnt_o) begin
                valid_d[tail_q]    = 1'b1;
                resolved_d[tail_q] = 1'b0;
                head_d[tail_q]     = allocHead_i;
                tail_d             = tail_q + 1'b1;
            end
            if (correct_event) begin
                resolved_d[resolveId_i] = 1'b1;
            end
            if (retire_event) begin
                valid_d[oldest_q]    = 1'b0;
                resolved_d[oldest_q] = 1'b0;
                oldest_d             = oldest_q + 1'b1;
            end
            if (mis_event) begin
                valid_d    = valid_d & ~squash;
                resolved_d = resolved_d & ~squash;
                tail_d     = resolveId_i;
                count_d    = (CP_LOG+1)'(age_k) - (CP_LOG+1)'(retire_event);
                flag_d     = 1'b1;
                fl_head_d  = head_q[resolveId_i];
                mask_d     = squash;
            end else begin
                count_d = count_q + (CP_LOG+1)'(allocGnt_o) - (CP_LOG+1)'(retire_event);
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            resolved_q <= '0;
            for (int i = 0; i < NUM_CP; i++) begin
                head_q[i] <= '0;
            end
            oldest_q   <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            flag_q     <= 1'b0;
            fl_head_q  <= '0;
            mask_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            head_q     <= head_d;
            oldest_q   <= oldest_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            flag_q     <= flag_d;
            fl_head_q  <= fl_head_d;
            mask_q     <= mask_d;
        end
    end

endmodule

// File: tb/tb_rename_checkpoint_ctrl.sv
// Directed, table-driven bench for rename_checkpoint_ctrl.
// Each row is driven at a falling edge and checked 1 ns later, before the next rising edge.
// Combinational outputs reflect the row's inputs.
// Registered outputs reflect the effect of the previous row.
module tb_rename_checkpoint_ctrl;

    localparam int NUM_CP = 8;
    localparam int CP_LOG = 3;
    localparam int FL_LOG = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall_i;
    logic              recoverFlag_i;
    logic              allocReq_i;
    logic [FL_LOG-1:0] allocHead_i;
    logic              allocGnt_o;
    logic [CP_LOG-1:0] allocId_o;
    logic              cpFull_o;
    logic              resolveValid_i;
    logic [CP_LOG-1:0] resolveId_i;
    logic              mispredict_i;
    logic              flagRecoverEX_o;
    logic              ctrlVerified_o;
    logic [FL_LOG-1:0] freeListHeadCp_o;
    logic [NUM_CP-1:0] squashMask_o;
    logic [CP_LOG:0]   cpCount_o;

    always #5 clk = ~clk;

    rename_checkpoint_ctrl #(.NUM_CP(NUM_CP), .CP_LOG(CP_LOG), .FL_LOG(FL_LOG)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall_i),
        .recoverFlag_i    (recoverFlag_i),
        .allocReq_i       (allocReq_i),
        .allocHead_i      (allocHead_i),
        .allocGnt_o       (allocGnt_o),
        .allocId_o        (allocId_o),
        .cpFull_o         (cpFull_o),
        .resolveValid_i   (resolveValid_i),
        .resolveId_i      (resolveId_i),
        .mispredict_i     (mispredict_i),
        .flagRecoverEX_o  (flagRecoverEX_o),
        .ctrlVerified_o   (ctrlVerified_o),
        .freeListHeadCp_o (freeListHeadCp_o),
        .squashMask_o     (squashMask_o),
        .cpCount_o        (cpCount_o)
    );

    typedef struct {
        int stall; int rec; int areq; int ahead;
        int rv; int rid; int mis;
        int gnt; int id; int full; int cnt;
        int flag; int fhead; int mask;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input int stall, input int rec, input int areq, input int ahead,
                       input int rv, input int rid, input int mis,
                       input int gnt, input int id, input int full, input int cnt,
                       input int flag, input int fhead, input int mask);
        vec_t v;
        v.stall = stall; v.rec = rec; v.areq = areq; v.ahead = ahead;
        v.rv = rv; v.rid = rid; v.mis = mis;
        v.gnt = gnt; v.id = id; v.full = full; v.cnt = cnt;
        v.flag = flag; v.fhead = fhead; v.mask = mask;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int step, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s step=%0d got=%0d expected=%0d", name, step, act, exp);
    endtask

    task automatic chk_all(input int step, input vec_t v);
        chk("allocGnt",   step, int'(allocGnt_o),       v.gnt);
        chk("allocId",    step, int'(allocId_o),        v.id);
        chk("cpFull",     step, int'(cpFull_o),         v.full);
        chk("cpCount",    step, int'(cpCount_o),        v.cnt);
        chk("flagRecEX",  step, int'(flagRecoverEX_o),  v.flag);
        chk("ctrlVerif",  step, int'(ctrlVerified_o),   v.flag);
        chk("flHeadCp",   step, int'(freeListHeadCp_o), v.fhead);
        chk("squashMask", step, int'(squashMask_o),     v.mask);
        $display("step %0d: stall=%0d rec=%0d areq=%0d head=%0d rv=%0d rid=%0d mis=%0d -> gnt=%0d id=%0d full=%0d cnt=%0d flag=%0d fh=%0d mask=%02h",
                 step, v.stall, v.rec, v.areq, v.ahead, v.rv, v.rid, v.mis,
                 allocGnt_o, allocId_o, cpFull_o, cpCount_o, flagRecoverEX_o,
                 freeListHeadCp_o, squashMask_o);
    endtask

    task automatic drive(input vec_t v);
        stall_i        = v.stall[0];
        recoverFlag_i  = v.rec[0];
        allocReq_i     = v.areq[0];
        allocHead_i    = FL_LOG'(v.ahead);
        resolveValid_i = v.rv[0];
        resolveId_i    = CP_LOG'(v.rid);
        mispredict_i   = v.mis[0];
    endtask

    initial begin
        vec_t idle;
        // Row fields:
        //   inputs:   stall, rec, areq, ahead, rv, rid, mis
        //   expected: gnt, id, full, cnt, flag, fhead, mask
        add(0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0);
        // Fill all eight checkpoints, then a ninth request is refused
        for (int i = 0; i < 8; i++) add(0,0,1,10+i, 0,0,0, 1,i,0,i, 0,0,0);
        add(0,0,1,18, 0,0,0, 0,0,1,8, 0,0,0);
        // Resolve id 0 correct while full: retires, and a new alloc wraps to id 0
        add(0,0,0,0,  1,0,0, 0,0,1,8, 0,0,0);
        add(0,0,1,30, 0,0,0, 1,0,0,7, 0,0,0);
        // Full flush with a concurrent alloc request
        add(0,1,1,31, 0,0,0, 0,1,1,8, 0,0,0);
        add(0,0,0,0,  0,0,0, 0,0,0,0, 0,0,0);
        // Ids 0..4 with heads 20..24; mispredict id 2 while rename also requests
        for (int i = 0; i < 5; i++) add(0,0,1,20+i, 0,0,0, 1,i,0,i, 0,0,0);
        add(0,0,1,25, 1,2,1, 0,5,0,5, 0,0,0);
        add(0,0,1,40, 0,0,0, 1,2,0,2, 1,22,8'h1C);
        add(0,0,0,0,  0,0,0, 0,3,0,3, 0,0,0);
        // In-order retire: resolve 3, then 0, then 2, then 1
        add(0,0,1,41, 0,0,0, 1,3,0,3, 0,0,0);
        add(0,0,0,0,  1,3,0, 0,4,0,4, 0,0,0);
        add(0,0,0,0,  1,0,0, 0,4,0,4, 0,0,0);
        add(0,0,0,0,  0,0,0, 0,4,0,3, 0,0,0);
        add(0,0,0,0,  0,0,0, 0,4,0,3, 0,0,0);
        add(0,0,0,0,  1,2,0, 0,4,0,3, 0,0,0);
        add(0,0,0,0,  1,1,0, 0,4,0,3, 0,0,0);
        add(0,0,0,0,  0,0,0, 0,4,0,2, 0,0,0);
        add(0,0,0,0,  0,0,0, 0,4,0,1, 0,0,0);
        add(0,0,0,0,  0,0,0, 0,4,0,0, 0,0,0);
        // Mispredict on an invalid id is ignored
        add(0,0,0,0,  1,6,1, 0,4,0,0, 0,0,0);
        add(0,0,0,0,  0,0,0, 0,4,0,0, 0,0,0);
        // Mispredict id 6 in the same cycle that oldest (5) retires
        for (int i = 0; i < 3; i++) add(0,0,1,50+i, 0,0,0, 1,4+i,0,i, 0,0,0);
        add(0,0,0,0,  1,5,0, 0,7,0,3, 0,0,0);
        add(0,0,0,0,  1,4,0, 0,7,0,3, 0,0,0);
        add(0,0,1,55, 1,6,1, 0,7,0,2, 0,0,0);
        add(0,0,0,0,  0,0,0, 0,6,0,0, 1,52,8'h40);
        add(0,0,0,0,  0,0,0, 0,6,0,0, 0,0,0);
        // Flush wins over a same-cycle mispredict: no pulse
        add(0,0,1,60, 0,0,0, 1,6,0,0, 0,0,0);
        add(0,0,1,61, 0,0,0, 1,7,0,1, 0,0,0);
        add(0,1,0,0,  1,6,1, 0,0,0,2, 0,0,0);
        add(0,0,0,0,  0,0,0, 0,0,0,0, 0,0,0);
        // Stall blocks allocation but not resolution or retire
        add(1,0,1,70, 0,0,0, 0,0,0,0, 0,0,0);
        add(0,0,1,70, 0,0,0, 1,0,0,0, 0,0,0);
        add(1,0,1,71, 1,0,0, 0,1,0,1, 0,0,0);
        add(0,0,0,0,  0,0,0, 0,1,0,0, 0,0,0);

        idle = '{default: 0};
        drive(idle);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_all(-1, idle);
        reset = 1'b0;

        for (int s = 0; s < vq.size(); s++) begin
            @(negedge clk);
            drive(vq[s]);
            #1;
            chk_all(s, vq[s]);
        end

        // Reset arriving together with a mispredict suppresses the pulse
        @(negedge clk);
        allocReq_i = 1'b1; allocHead_i = 7'd5;
        #1;
        chk("pre_rst_gnt", 100, int'(allocGnt_o), 1);
        chk("pre_rst_id",  100, int'(allocId_o),  1);
        $display("step 100: alloc head=5 -> gnt=%0d id=%0d", allocGnt_o, allocId_o);
        @(negedge clk);
        allocReq_i = 1'b0;
        resolveValid_i = 1'b1; resolveId_i = 3'd1; mispredict_i = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        resolveValid_i = 1'b0; mispredict_i = 1'b0;
        #1;
        chk("rst_mid_flag",  101, int'(flagRecoverEX_o),  0);
        chk("rst_mid_vrf",   101, int'(ctrlVerified_o),   0);
        chk("rst_mid_head",  101, int'(freeListHeadCp_o), 0);
        chk("rst_mid_count", 101, int'(cpCount_o),        0);
        chk("rst_mid_id",    101, int'(allocId_o),        0);
        $display("step 101: mispredict+reset -> flag=%0d cnt=%0d id=%0d", flagRecoverEX_o, cpCount_o, allocId_o);
        @(negedge clk);
        #1;
        chk("rst_after_flag", 102, int'(flagRecoverEX_o), 0);
        $display("step 102: idle -> flag=%0d", flagRecoverEX_o);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
